// File: rtl/layernorm_buf_pkg.sv
// Shared definitions for the LayerNorm input vector buffer.
// Provides width helpers for pointers/counters, default datapath constants
// and lane-slice helpers (lane 0 occupies the LSBs of an entry).
package layernorm_buf_pkg;

    localparam int DEF_WIDTH   = 9;
    localparam int DEF_LANES   = 4;
    localparam int DEF_VEC_LEN = 4;
    localparam int DEF_DATA_W  = DEF_WIDTH * DEF_LANES;

    // Lane n of an entry occupies bits [lane_lo(n)+WIDTH-1 : lane_lo(n)].
    localparam int LANE0_LO = 0;
    localparam int LANE1_LO = DEF_WIDTH;
    localparam int LANE2_LO = 2 * DEF_WIDTH;
    localparam int LANE3_LO = 3 * DEF_WIDTH;

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    // Address width for a memory of n entries (at least one bit).
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/layernorm_vec_buffer_if.sv
// Handshake bundle between the LayerNorm vector buffer and its neighbours.
//   master : producer/consumer side (drives write request, data, read ready)
//   slave  : the buffer (drives ready/valid, read data, status flags)
interface layernorm_vec_buffer_if
    import layernorm_buf_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LANES  = DEF_LANES,
    parameter int DEPTH  = 16,
    parameter int PASSES = 2
) ();

    logic                          i_wr_valid;
    logic [WIDTH*LANES-1:0]        i_wr_data;
    logic                          o_wr_ready;
    logic                          o_rd_valid;
    logic [WIDTH*LANES-1:0]        o_rd_data;
    logic                          i_rd_ready;
    logic                          o_rd_last;
    logic [cnt_w(PASSES)-1:0]      o_pass;
    logic [cnt_w(DEPTH)-1:0]       o_count;
    logic                          o_almost_full;
    logic                          o_ovf;

    modport master (
        output i_wr_valid, i_wr_data, i_rd_ready,
        input  o_wr_ready, o_rd_valid, o_rd_data, o_rd_last, o_pass,
               o_count, o_almost_full, o_ovf
    );

    modport slave (
        input  i_wr_valid, i_wr_data, i_rd_ready,
        output o_wr_ready, o_rd_valid, o_rd_data, o_rd_last, o_pass,
               o_count, o_almost_full, o_ovf
    );

endinterface

// File: rtl/layernorm_buf_ram.sv
// Simple dual-port storage for the vector buffer.
//   i_clk   : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address (asynchronous read)
//   o_rdata : read data
// Contents are never reset.
module layernorm_buf_ram
    import layernorm_buf_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_W-1:0]         i_wdata,
    input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
    output logic [DATA_W-1:0]         o_rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/layernorm_vec_buffer.sv
// Multi-lane, vector-aware input FIFO for the LayerNorm datapath.
// Entries of LANES signed elements are grouped into vectors of VEC_LEN
// entries; each vector is replayed PASSES times before its slots are freed.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : write handshake, first-word-fall-through read handshake,
//           replay position (o_rd_last, o_pass) and status
//           (o_count, o_almost_full, sticky o_ovf)
//
// Replay state:
//   pass   | offset        | meaning
//   0      | 0..VEC_LEN-1  | statistics pass, may stream behind the writer
//   1..P-1 | 0..VEC_LEN-1  | later passes over data already stored
//   P-1    | VEC_LEN-1     | accepting this entry frees the whole vector
module layernorm_vec_buffer
    import layernorm_buf_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LANES     = DEF_LANES,
    parameter int DEPTH     = 16,
    parameter int VEC_LEN   = DEF_VEC_LEN,
    parameter int PASSES    = 2,
    parameter int AF_THRESH = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    layernorm_vec_buffer_if.slave  bus
);

    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);
    localparam int PASS_W = cnt_w(PASSES);
    localparam int DATA_W = WIDTH * LANES;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  base_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  offset;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [PASS_W-1:0] pass;
    logic              ovf;

    logic              wr_ready;
    logic              rd_valid;
    logic              at_last;
    logic              final_pass;
    logic              wr_fire;
    logic              rd_fire;
    logic              free_vec;
    logic [DATA_W-1:0] ram_rdata;

    assign wr_ready   = (count < CNT_W'(DEPTH));
    // offset never exceeds VEC_LEN-1 <= DEPTH-1, so its low bits address the RAM.
    assign rd_ptr     = base_ptr + offset[PTR_W-1:0];
    assign rd_valid   = (offset < count);
    assign at_last    = (offset == CNT_W'(VEC_LEN - 1));
    assign final_pass = (pass == PASS_W'(PASSES - 1));
    assign wr_fire    = bus.i_wr_valid & wr_ready;
    assign rd_fire    = rd_valid & bus.i_rd_ready;
    assign free_vec   = rd_fire & at_last & final_pass;

    always_comb begin
        count_nxt = count;
        if (wr_fire) begin
            count_nxt = count_nxt + CNT_W'(1);
        end
        if (free_vec) begin
            count_nxt = count_nxt - CNT_W'(VEC_LEN);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            base_ptr <= '0;
            offset   <= '0;
            pass     <= '0;
            count    <= '0;
            ovf      <= 1'b0;
        end else begin
            count <= count_nxt;
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (bus.i_wr_valid && !wr_ready) begin
                ovf <= 1'b1;
            end
            if (rd_fire) begin
                if (!at_last) begin
                    offset <= offset + CNT_W'(1);
                end else begin
                    offset <= '0;
                    if (final_pass) begin
                        pass     <= '0;
                        base_ptr <= base_ptr + PTR_W'(VEC_LEN);
                    end else begin
                        pass <= pass + PASS_W'(1);
                    end
                end
            end
        end
    end

    layernorm_buf_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (wr_fire),
        .i_waddr (wr_ptr),
        .i_wdata (bus.i_wr_data),
        .i_raddr (rd_ptr),
        .o_rdata (ram_rdata)
    );

    assign bus.o_wr_ready    = wr_ready;
    assign bus.o_rd_valid    = rd_valid;
    assign bus.o_rd_data     = rd_valid ? ram_rdata : '0;
    assign bus.o_rd_last     = rd_valid & at_last;
    assign bus.o_pass        = pass;
    assign bus.o_count       = count;
    assign bus.o_almost_full = (count >= CNT_W'(AF_THRESH));
    assign bus.o_ovf         = ovf;

endmodule

// File: tb/tb_layernorm_vec_buffer.sv
// Self-checking bench for layernorm_vec_buffer: directed steps plus a random
// streaming phase, checked against a queue-based reference model.
module tb_layernorm_vec_buffer;
    import layernorm_buf_pkg::*;

    localparam int WIDTH   = 9;
    localparam int LANES   = 4;
    localparam int DEPTH   = 16;
    localparam int VEC_LEN = 4;
    localparam int PASSES  = 2;
    localparam int AF      = 12;
    localparam int DW      = WIDTH * LANES;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    layernorm_vec_buffer_if #(
        .WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH), .PASSES(PASSES)
    ) bus ();

    layernorm_vec_buffer #(
        .WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH), .VEC_LEN(VEC_LEN),
        .PASSES(PASSES), .AF_THRESH(AF)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: unfreed entries in arrival order, position within the
    // whole replay of the head vector (0 .. VEC_LEN*PASSES-1), sticky overflow.
    logic [DW-1:0] mq[$];
    int            rep_pos = 0;
    bit            m_ovf   = 1'b0;

    logic [DW-1:0] obs_data;
    logic          obs_valid;
    logic          obs_last;
    logic [63:0]   obs_pass;
    logic          obs_af;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int v);
        logic [DW-1:0] d;
        d = DW'({$urandom, $urandom});
        d[lane_lo(0, WIDTH) +: WIDTH] = WIDTH'(v);
        return d;
    endfunction

    // Drive one cycle, check every output against the model before the edge,
    // then advance the model by what the edge accepts.
    task automatic cycle(input bit wv, input logic [DW-1:0] wd, input bit rr);
        int            off;
        bit            ev;
        logic [DW-1:0] ed;
        bit            wf;
        bit            rf;
        bus.i_wr_valid = wv;
        bus.i_wr_data  = wd;
        bus.i_rd_ready = rr;
        #1;
        off = rep_pos % VEC_LEN;
        ev  = (off < mq.size());
        ed  = ev ? mq[off] : '0;
        chk("rd_valid",    64'(bus.o_rd_valid),    64'(ev));
        chk("rd_data",     64'(bus.o_rd_data),     64'(ed));
        chk("rd_last",     64'(bus.o_rd_last),     64'(ev && off == VEC_LEN - 1));
        chk("pass",        64'(bus.o_pass),        64'(rep_pos / VEC_LEN));
        chk("count",       64'(bus.o_count),       64'(mq.size()));
        chk("wr_ready",    64'(bus.o_wr_ready),    64'(mq.size() < DEPTH));
        chk("almost_full", 64'(bus.o_almost_full), 64'(mq.size() >= AF));
        chk("ovf",         64'(bus.o_ovf),         64'(m_ovf));
        obs_data  = bus.o_rd_data;
        obs_valid = bus.o_rd_valid;
        obs_last  = bus.o_rd_last;
        obs_pass  = 64'(bus.o_pass);
        obs_af    = bus.o_almost_full;
        wf = wv && (mq.size() < DEPTH);
        rf = rr && ev;
        @(posedge i_clk);
        if (wv && !wf) m_ovf = 1'b1;
        if (rf) begin
            rep_pos++;
            if (rep_pos == VEC_LEN * PASSES) begin
                repeat (VEC_LEN) void'(mq.pop_front());
                rep_pos = 0;
            end
        end
        if (wf) mq.push_back(wd);
        @(negedge i_clk);
    endtask

    task automatic do_reset(input bit wv);
        bus.i_wr_valid = wv;
        bus.i_wr_data  = mk(77);
        bus.i_rd_ready = 1'b0;
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        bus.i_wr_valid = 1'b0;
        mq.delete();
        rep_pos = 0;
        m_ovf   = 1'b0;
        #1;
    endtask

    initial begin
        int            exp_l0 [8] = '{1, 2, 3, 4, 1, 2, 3, 4};
        int            written;
        int            cyc;
        bit            wv;
        bit            rr;
        bit            prev_stall;
        logic [DW-1:0] prev_data;

        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_rd_ready = 1'b0;

        // Reset held two cycles while a write is requested.
        do_reset(1'b1);
        chk("rst_count",    64'(bus.o_count),       64'd0);
        chk("rst_rd_valid", 64'(bus.o_rd_valid),    64'd0);
        chk("rst_wr_ready", 64'(bus.o_wr_ready),    64'd1);
        chk("rst_ovf",      64'(bus.o_ovf),         64'd0);
        chk("rst_pass",     64'(bus.o_pass),        64'd0);
        chk("rst_rd_last",  64'(bus.o_rd_last),     64'd0);
        chk("rst_rd_data",  64'(bus.o_rd_data),     64'd0);
        chk("rst_af",       64'(bus.o_almost_full), 64'd0);

        // Replay: one vector read twice.
        for (int v = 1; v <= 4; v++) cycle(1'b1, mk(v), 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 1'b1);
            chk("replay_lane0", 64'(obs_data[WIDTH-1:0]), 64'(exp_l0[i]));
            chk("replay_last",  64'(obs_last), 64'(i == 3 || i == 7));
            chk("replay_pass",  obs_pass, 64'(i / 4));
        end
        chk("replay_count_end", 64'(bus.o_count), 64'd0);

        // Fill to full, then overflow with 99.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, mk(100 + i), 1'b0);
            chk("fill_af", 64'(obs_af), 64'(i >= AF));
        end
        chk("full_wr_ready", 64'(bus.o_wr_ready), 64'd0);
        cycle(1'b1, mk(99), 1'b0);
        chk("ovf_set",   64'(bus.o_ovf),   64'd1);
        chk("ovf_count", 64'(bus.o_count), 64'(DEPTH));
        for (int i = 0; i < DEPTH * PASSES; i++) begin
            cycle(1'b0, '0, 1'b1);
            chk("no_99", 64'(obs_valid && obs_data[WIDTH-1:0] == WIDTH'(99)), 64'd0);
        end
        chk("drain_count", 64'(bus.o_count), 64'd0);
        do_reset(1'b0);

        // Write coinciding with the final free.
        for (int i = 0; i < 8; i++) cycle(1'b1, mk(20 + i), 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, mk(50), 1'b1);
        chk("simul_count", 64'(bus.o_count), 64'd5);
        do_reset(1'b0);

        // Random streaming across pointer wrap with stalls.
        written    = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while ((written < 40 || mq.size() > 0) && cyc < 3000) begin
            wv = (written < 40) && ($urandom_range(9) < 6);
            rr = ($urandom_range(9) < 5);
            if (wv && mq.size() < DEPTH) written++;
            cycle(wv, mk($urandom_range(255)), rr);
            if (prev_stall) chk("stall_hold", 64'(obs_data), 64'(prev_data));
            prev_stall = obs_valid && !rr;
            prev_data  = obs_data;
            cyc++;
        end
        chk("random_drained", 64'(cyc < 3000), 64'd1);
        chk("random_written", 64'(written), 64'd40);

        // Reset at pass 1, offset 2.
        do_reset(1'b0);
        for (int v = 10; v <= 13; v++) cycle(1'b1, mk(v), 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
        chk("mid_pass_before", 64'(bus.o_pass), 64'd1);
        do_reset(1'b0);
        chk("mid_rst_pass",     64'(bus.o_pass),     64'd0);
        chk("mid_rst_count",    64'(bus.o_count),    64'd0);
        chk("mid_rst_rd_valid", 64'(bus.o_rd_valid), 64'd0);
        for (int v = 5; v <= 8; v++) cycle(1'b1, mk(v), 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("mid_new_first", 64'(obs_data[WIDTH-1:0]), 64'd5);
        chk("mid_new_pass",  obs_pass, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layernorm_vec_buffer.md
Name: layernorm_vec_buffer

Overview:
- Multi-lane, vector-aware input FIFO at the front of the LayerNorm datapath.
- Stores LANES signed elements per entry and groups entries into vectors of VEC_LEN entries.
- Replays each stored vector PASSES times (statistics pass, then normalise pass) before freeing it.
- Supersedes the single-lane input buffer. Adds valid/ready handshakes, a true full flag, an almost-full flag, overflow detection and replay.

Parameters:
- WIDTH, 9: bits per signed element.
- LANES, 4: elements per entry.
- DEPTH, 16: entries stored; power of two, DEPTH >= VEC_LEN.
- VEC_LEN, 4: entries per LayerNorm vector; 1 <= VEC_LEN <= DEPTH.
- PASSES, 2: read passes per vector; 1 gives a plain FIFO.
- AF_THRESH, 12: almost-full threshold in entries; 1 <= AF_THRESH <= DEPTH.

Ports:
- i_clk, in, 1: clock; all logic on the rising edge.
- i_rst, in, 1: synchronous, active-high reset.
- i_wr_valid, in, 1: write request.
- i_wr_data, in, LANES*WIDTH: entry; lane 0 in the LSBs.
- o_wr_ready, out, 1: space available.
- o_rd_valid, out, 1: entry available at the read pointer.
- o_rd_data, out, LANES*WIDTH: current entry.
- i_rd_ready, in, 1: consumer accepts the entry.
- o_rd_last, out, 1: current entry is the last entry of its vector.
- o_pass, out, clog2(PASSES)+1: current pass index of the vector at the head.
- o_count, out, clog2(DEPTH)+1: entries held and not yet freed.
- o_almost_full, out, 1: o_count >= AF_THRESH.
- o_ovf, out, 1: sticky; a write was attempted while not ready.

Behaviour:
- One clock (i_clk). Reset is synchronous and active-high (i_rst), sampled on the rising edge.
- Reset clears wr_ptr, rd_ptr, base_ptr, pass, offset, count and o_ovf.
  - After reset: o_rd_valid=0, o_wr_ready=1, o_rd_last=0, o_pass=0, o_count=0, o_almost_full=0, o_ovf=0, o_rd_data=0.
  - Memory contents are not cleared.
  - Reset mid-vector discards all stored data and the replay state.
- Write handshake: i_wr_valid & o_wr_ready.
  - Stores at mem[wr_ptr]; wr_ptr increments mod DEPTH; count +1.
  - o_wr_ready = (count < DEPTH): true full, with no one-slot loss.
  - i_wr_valid while o_wr_ready=0: data is dropped, o_ovf is set, no other state changes.
- Read side is first-word-fall-through with zero read latency.
  - offset is the position within the current pass, 0..VEC_LEN-1; rd_ptr = (base_ptr + offset) mod DEPTH.
  - o_rd_valid = (offset < count).
  - o_rd_data = mem[rd_ptr] when valid, else 0.
  - Data written in cycle N is readable in cycle N+1.
  - o_rd_last = o_rd_valid & (offset == VEC_LEN-1).
- Read handshake: o_rd_valid & i_rd_ready.
  - Not last: offset +1.
  - Last with pass < PASSES-1: offset <= 0, pass +1; nothing is freed.
  - Last with pass == PASSES-1: base_ptr += VEC_LEN (mod DEPTH), offset <= 0, pass <= 0, count -= VEC_LEN.
- While i_rd_ready=0, o_rd_data and o_rd_last hold stable.
- Pass 0 may stream while the vector is still being written. Later passes read data already present.
- Simultaneous accepted write and final free: count <= count + 1 - VEC_LEN in the same cycle.
- Pointers wrap naturally at DEPTH; count disambiguates full from empty.
- o_almost_full is combinational from count.

Decomposition:
- Shared package layernorm_buf_pkg:
  - pointer/count width helper (clog2-based);
  - default constants WIDTH, LANES, VEC_LEN;
  - lane-slice localparams.
- Sub-module layernorm_buf_ram:
  - simple dual-port memory, DEPTH x LANES*WIDTH;
  - synchronous write, asynchronous read;
  - no reset.
- Pointer, replay and count control stays in layernorm_vec_buffer.

Test Plan:
- Reset: assert i_rst for 2 cycles with i_wr_valid=1 -> o_count=0, o_rd_valid=0, o_wr_ready=1, o_ovf=0, no write accepted.
- Replay: write entries with lane0 values 1,2,3,4; hold i_rd_ready=1.
  - Output lane0 is 1,2,3,4,1,2,3,4.
  - o_rd_last is high on outputs 4 and 8; o_pass is 0 then 1.
  - o_count stays 4 until the 8th handshake, then reads 0.
- Full/overflow: write 16 entries with no reads.
  - o_almost_full is high from count 12; o_wr_ready=0 at count 16.
  - A 17th write with value 99 gives o_ovf=1, o_count=16, and 99 never appears at the output.
- Simultaneous: at count 8, on the final-pass last handshake, also write one entry -> o_count=5 next cycle.
- Stall and wrap: stream 40 entries with random i_rd_ready and i_wr_valid.
  - Output equals the reference model (each vector twice, in order) across pointer wrap.
  - Data holds while i_rd_ready=0.
- Reset mid-replay: assert i_rst at pass 1, offset 2.
  - State clears.
  - A new vector 5,6,7,8 is read at pass 0 starting with 5.
